// File: rtl/sram_responder_if.sv
// Pin bus between an async-SRAM controller and the chip-side responder.
// The bidirectional data pins are a plain inout on the responder, not part of this bundle.
interface sram_responder_if;
    logic [19:0] pinAddr;
    logic        pinCE;
    logic        pinOE;
    logic        pinWE;
    logic        pinUB;
    logic        pinLB;
    logic [7:0]  pinWrCount;
    logic [7:0]  pinRdCount;
    logic        pinErr;
    logic [15:0] pinLastData;

    modport master (
        output pinAddr, pinCE, pinOE, pinWE, pinUB, pinLB,
        input  pinWrCount, pinRdCount, pinErr, pinLastData
    );

    modport slave (
        input  pinAddr, pinCE, pinOE, pinWE, pinUB, pinLB,
        output pinWrCount, pinRdCount, pinErr, pinLastData
    );
endinterface

// File: rtl/sram_responder.sv
// Chip-side model of a 16-bit async SRAM: answers CE/OE/WE/UB/LB cycles from an
// internal array, counts committed writes and served reads, flags OE+WE overlap.
module sram_responder #(
    parameter int unsigned MEM_AW    = 4,
    parameter logic [19:0] BASE_ADDR = 20'd0,
    parameter int unsigned READ_LAT  = 0,
    parameter logic [15:0] FILL      = 16'hDEAD
) (
    input  logic              clock_50mhz,
    input  logic              pinReset,
    sram_responder_if.slave   bus,
    inout  wire  [15:0]       pinData
);

    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam bit          LAT0  = (READ_LAT == 0);

    typedef enum logic [1:0] {IDLE, WR_ACT, RD_WAIT, RD_DRV} state_t;

    state_t      state;
    logic [15:0] mem [DEPTH];
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ub;
    logic        wr_lb;
    logic [1:0]  lat_cnt;
    logic [7:0]  wr_count;
    logic [7:0]  rd_count;
    logic        err;
    logic [15:0] last_data;

    logic        wr_c;
    logic        rd_c;
    logic [15:0] old_word_c;
    logic [15:0] merged_c;
    logic        commit_ok_c;
    logic [15:0] rd_word_c;
    logic        drive_c;

    // Window decode on the address bits above the array index
    function automatic logic hit(input logic [19:0] a);
        return a[19:MEM_AW] == BASE_ADDR[19:MEM_AW];
    endfunction

    // Pin decode; WE low always means write, so a write can never also drive the bus
    assign wr_c = !bus.pinCE && !bus.pinWE;
    assign rd_c = !bus.pinCE && !bus.pinOE && bus.pinWE;

    // Lane merge of the latched write against the current array word
    assign old_word_c  = mem[wr_addr[MEM_AW-1:0]];
    assign merged_c    = {wr_ub ? old_word_c[15:8] : wr_data[15:8],
                          wr_lb ? old_word_c[7:0]  : wr_data[7:0]};
    assign commit_ok_c = hit(wr_addr) && !(wr_ub && wr_lb);

    // Read path follows the live address so an address change shows the new word
    assign rd_word_c = hit(bus.pinAddr) ? mem[bus.pinAddr[MEM_AW-1:0]] : FILL;
    assign drive_c   = pinReset && rd_c &&
                       ((state == RD_DRV) || (LAT0 && (state == IDLE)));

    // Per-lane tristate drivers, released as soon as CE/OE rise or reset asserts
    assign pinData[15:8] = (drive_c && !bus.pinUB) ? rd_word_c[15:8] : 8'hzz;
    assign pinData[7:0]  = (drive_c && !bus.pinLB) ? rd_word_c[7:0]  : 8'hzz;

    // Cycle FSM, write latch/commit, counters and sticky error
    always_ff @(posedge clock_50mhz or negedge pinReset) begin
        if (!pinReset) begin
            state     <= IDLE;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_ub     <= 1'b1;
            wr_lb     <= 1'b1;
            lat_cnt   <= '0;
            wr_count  <= '0;
            rd_count  <= '0;
            err       <= 1'b0;
            last_data <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_c && !bus.pinOE) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (wr_c) begin
                        wr_addr <= bus.pinAddr;
                        wr_data <= pinData;
                        wr_ub   <= bus.pinUB;
                        wr_lb   <= bus.pinLB;
                        state   <= WR_ACT;
                    end else if (rd_c) begin
                        if (LAT0) begin
                            rd_count <= rd_count + 8'd1;
                            state    <= RD_DRV;
                        end else begin
                            lat_cnt <= '0;
                            state   <= RD_WAIT;
                        end
                    end
                end
                WR_ACT: begin
                    if (wr_c) begin
                        wr_addr <= bus.pinAddr;
                        wr_data <= pinData;
                        wr_ub   <= bus.pinUB;
                        wr_lb   <= bus.pinLB;
                    end else begin
                        if (commit_ok_c) begin
                            mem[wr_addr[MEM_AW-1:0]] <= merged_c;
                            wr_count                 <= wr_count + 8'd1;
                            last_data                <= merged_c;
                        end
                        state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (!rd_c) begin
                        state <= IDLE;
                    end else if (lat_cnt == 2'(READ_LAT - 1)) begin
                        rd_count <= rd_count + 8'd1;
                        state    <= RD_DRV;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RD_DRV: begin
                    if (!rd_c) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pinWrCount  = wr_count;
    assign bus.pinRdCount  = rd_count;
    assign bus.pinErr      = err;
    assign bus.pinLastData = last_data;

endmodule
